keypad_enc: RTL and testbench
=============================

Name: keypad_enc

Overview:
- Input-side counterpart of the extended 7-segment decoder. It turns the board's push-button vector into the same 5-bit code space the decoder consumes.
- Codes: 0x00-0x0F are hex digits; 0x10-0x13 are the four Simon colour keys.
- Synchronises, debounces and priority-encodes presses, then emits one strobe per accepted press. The game FSM and score display consume `code`/`strobe` directly.

Parameters:
- N_KEYS, 20: number of push-buttons encoded; legal range 1..32; key i maps to code i.
- DEBOUNCE, 3: consecutive stable synchronised samples required before a change is accepted; legal range >= 1 (3 = 30 ms at hz100).

Ports:
- hz100  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  gates new-press acceptance; mirrors the decoder's enable.
- pb  in  N_KEYS  raw, asynchronous, active-high buttons.
- code  out  5  code of the last accepted press; held until the next accepted press.
- strobe  out  1  one-cycle pulse, concurrent with a new `code` value.
- held  out  1  high while the accepted key's debounced vector is non-zero (FSM in HELD).
- multi  out  1  registered; high when the debounced vector has more than one bit set.

Behaviour:
- Reset (async, immediate): sync1 = sync2 = cand = deb = 0; cnt = 0; state = IDLE; code = 0; strobe = 0; held = 0; multi = 0.
- Synchroniser: 2 flops. sync1 <= pb; raw = sync2.
- Debounce, per edge:
  - if raw != cand: cand <= raw, cnt <= 0;
  - else if cnt == DEBOUNCE-1: deb <= cand (cnt holds, saturates);
  - else: cnt <= cnt+1.
  - Any bounce restarts the window.
- Latency: pb first sampled high at edge k, stable afterwards.
  - deb updates at edge k+2+DEBOUNCE.
  - strobe is high in the cycle after edge k+3+DEBOUNCE (edge k+6 for the default).
- FSM states IDLE, HELD:
  - IDLE, deb != 0, enable = 1: code <= index of lowest set bit of deb; strobe <= 1; go to HELD.
  - IDLE, deb != 0, enable = 0: no strobe, stay in IDLE. A press still held when enable rises is accepted on the next edge.
  - HELD, deb == 0: go to IDLE. Otherwise stay; additional keys are ignored and produce no strobe.
  - strobe <= 0 on every edge not listed above. It is never high for two consecutive cycles.
- Simultaneous presses (same debounced edge): lowest index wins; multi = 1.
- Re-press of the same key after full release (deb == 0 observed for at least one edge): new strobe with the same code.
- Width: code = 5-bit zero-extended index. Bits of pb at and above N_KEYS do not exist.
- Reset mid-press: all outputs clear immediately. After reset releases, a still-held key is re-accepted after the full sync + debounce latency.
- enable does not affect code, held or multi.

Decomposition:
- Package simon_pkg:
  - typedef key_code_t (logic [4:0]);
  - constants KEY_RED = 5'h10, KEY_GRN = 5'h11, KEY_BLU = 5'h12, KEY_YEL = 5'h13, KEY_NONE = 5'h1F;
  - enum kenc_state_t {IDLE, HELD}.
- Sub-module keypad_debounce (params N, DEBOUNCE): synchroniser plus debounce counter, outputs deb[N-1:0].
- keypad_enc holds the priority encoder, FSM and output registers.

Test Plan:
- Clean press: pb[5] rises before edge 1, held 20 cycles → strobe pulses once in the cycle after edge 7; code = 0x05; held = 1 until about 5 cycles after release.
- Bounce: pb[16] toggles on, off, on at 1-cycle spacing, then stays on → exactly one strobe with code = 0x10, timed from the last toggle.
- Simultaneous: pb[3] and pb[17] rise together → one strobe; code = 0x03; multi = 1.
- Hold plus second key: pb[3] held, then pb[1] added → no further strobe and code stays 0x03. Release both, press pb[1] → strobe with code = 0x01.
- Enable gating: pb[19] held with enable = 0 for 10 cycles → no strobe. Raise enable → strobe with code = 0x13 one edge later.
- Async reset: assert reset mid-strobe cycle → strobe, code and held go to 0 immediately. Key still held after reset releases → strobe again after 2 + DEBOUNCE + 1 edges.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types and key codes for the Simon game datapath.
// Contents:
//   key_code_t   - 5-bit code space shared with the extended 7-segment decoder
//   KEY_*        - colour-key codes (0x10-0x13) and the "no key" marker
//   kenc_state_t - keypad encoder FSM states
package simon_pkg;

    typedef logic [4:0] key_code_t;

    localparam key_code_t KEY_RED  = 5'h10;
    localparam key_code_t KEY_GRN  = 5'h11;
    localparam key_code_t KEY_BLU  = 5'h12;
    localparam key_code_t KEY_YEL  = 5'h13;
    localparam key_code_t KEY_NONE = 5'h1F;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } kenc_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Two-flop synchroniser followed by a whole-vector debounce filter.
// The debounced vector only changes after the synchronised vector has been
// identical for DEBOUNCE consecutive edges; any change restarts the window.
// Ports:
//   i_clk - clock, rising edge
//   i_rst - asynchronous active-high reset
//   i_pb  - raw asynchronous button vector
//   o_deb - debounced button vector
module keypad_debounce #(
    parameter int unsigned N        = 20,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_pb,
    output logic [N-1:0] o_deb
);

    localparam int unsigned      CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    logic [N-1:0]     r_sync1;
    logic [N-1:0]     r_sync2;
    logic [N-1:0]     r_cand;
    logic [N-1:0]     r_deb;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_deb   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_pb;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_cand) begin
                r_cand <= r_sync2;
                r_cnt  <= '0;
            end else if (r_cnt == CNT_MAX) begin
                // Counter saturates here; deb keeps tracking the stable candidate.
                r_deb <= r_cand;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/keypad_enc.sv
// Keypad encoder: debounces the push-button vector, priority-encodes the
// lowest pressed key and emits one strobe per accepted press.
// Ports:
//   hz100  - system clock, rising edge
//   reset  - asynchronous active-high reset
//   enable - gates acceptance of new presses
//   pb     - raw asynchronous active-high buttons, key i -> code i
//   code   - code of the last accepted press, held until the next one
//   strobe - one-cycle pulse concurrent with a new code
//   held   - high while the accepted press is still down (FSM in HELD)
//   multi  - registered, more than one debounced key down
module keypad_enc
    import simon_pkg::*;
#(
    parameter int unsigned N_KEYS   = 20,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic              hz100,
    input  logic              reset,
    input  logic              enable,
    input  logic [N_KEYS-1:0] pb,
    output logic [4:0]        code,
    output logic              strobe,
    output logic              held,
    output logic              multi
);

    logic [N_KEYS-1:0] w_deb;
    logic              w_any;
    logic              w_multi;
    logic              w_accept;
    key_code_t         w_low_idx;
    key_code_t         w_code_next;
    logic              w_strobe_next;
    kenc_state_t       w_state_next;

    kenc_state_t       r_state;
    key_code_t         r_code;
    logic              r_strobe;
    logic              r_multi;

    keypad_debounce #(
        .N        (N_KEYS),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .i_clk (hz100),
        .i_rst (reset),
        .i_pb  (pb),
        .o_deb (w_deb)
    );

    assign w_any   = |w_deb;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(w_deb & (w_deb - N_KEYS'(1)));

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        w_low_idx = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (w_deb[i]) begin
                w_low_idx = key_code_t'(i);
            end
        end
    end

    // State register
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_any && enable) begin
                    w_state_next = HELD;
                end
            end
            HELD: begin
                if (!w_any) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic (next values of the registered outputs)
    always_comb begin
        w_accept      = (r_state == IDLE) && w_any && enable;
        w_strobe_next = w_accept;
        w_code_next   = w_accept ? w_low_idx : r_code;
    end

    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            r_code   <= '0;
            r_strobe <= 1'b0;
            r_multi  <= 1'b0;
        end else begin
            r_code   <= w_code_next;
            r_strobe <= w_strobe_next;
            r_multi  <= w_multi;
        end
    end

    assign code   = r_code;
    assign strobe = r_strobe;
    assign held   = (r_state == HELD);
    assign multi  = r_multi;

endmodule

// File: tb/tb_keypad_enc.sv
// Scoreboard bench for keypad_enc: stimulus pushes the expected strobe
// (code, cycle, multi) into a queue; the monitor pops on every strobe.
module tb_keypad_enc;
    import simon_pkg::*;

    localparam int unsigned NK  = 20;
    localparam int unsigned DB  = 3;
    // Drive at a negedge after edge n -> strobe visible at negedge after edge n+LAT.
    localparam int unsigned LAT = 2 + DB + 2;

    typedef struct {
        logic [4:0]  code;
        int unsigned cyc;
        logic        multi;
    } exp_t;

    logic          hz100 = 1'b0;
    logic          reset;
    logic          enable;
    logic [NK-1:0] pb;
    logic [4:0]    code;
    logic          strobe;
    logic          held;
    logic          multi;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    exp_t        sb_q[$];
    logic        prev_strobe = 1'b0;

    keypad_enc #(
        .N_KEYS   (NK),
        .DEBOUNCE (DB)
    ) dut (
        .hz100  (hz100),
        .reset  (reset),
        .enable (enable),
        .pb     (pb),
        .code   (code),
        .strobe (strobe),
        .held   (held),
        .multi  (multi)
    );

    always #5 hz100 = ~hz100;
    always @(posedge hz100) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_strobe(logic [4:0] c, int unsigned at, logic m);
        exp_t e;
        e.code  = c;
        e.cyc   = at;
        e.multi = m;
        sb_q.push_back(e);
    endfunction

    // Monitor
    always @(negedge hz100) begin
        if (strobe === 1'b1) begin
            check("strobe_back_to_back", {31'd0, prev_strobe}, 32'd0);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got code 0x%0h, expected no strobe (cycle %0d)",
                         code, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("strobe_code", {27'd0, code}, {27'd0, e.code});
                check("strobe_cycle", cyc, e.cyc);
                check("strobe_multi", {31'd0, multi}, {31'd0, e.multi});
                check("strobe_held", {31'd0, held}, 32'd1);
            end
        end
        prev_strobe = strobe;
    end

    task automatic wait_neg(int n);
        repeat (n) @(negedge hz100);
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        pb     = '0;
        #1;
        check("reset_code", {27'd0, code}, 32'd0);
        check("reset_strobe", {31'd0, strobe}, 32'd0);
        check("reset_held", {31'd0, held}, 32'd0);
        check("reset_multi", {31'd0, multi}, 32'd0);
        wait_neg(1);
        reset = 1'b0;
        wait_neg(2);

        // Clean press of key 5
        pb[5] = 1'b1;
        expect_strobe(5'h05, cyc + LAT, 1'b0);
        wait_neg(20);
        check("clean_held", {31'd0, held}, 32'd1);
        pb = '0;
        wait_neg(LAT);
        check("clean_release_held", {31'd0, held}, 32'd0);
        check("clean_code_kept", {27'd0, code}, 32'h05);

        // Bounce on key 16: on, off, on
        pb[16] = 1'b1;
        wait_neg(1);
        pb[16] = 1'b0;
        wait_neg(1);
        pb[16] = 1'b1;
        expect_strobe(KEY_RED, cyc + LAT, 1'b0);
        wait_neg(12);
        pb = '0;
        wait_neg(LAT + 1);

        // Simultaneous keys 3 and 17
        pb[3]  = 1'b1;
        pb[17] = 1'b1;
        expect_strobe(5'h03, cyc + LAT, 1'b1);
        wait_neg(12);
        pb = '0;
        wait_neg(LAT + 1);
        check("simul_multi_clear", {31'd0, multi}, 32'd0);

        // Hold key 3, add key 1: no second strobe
        pb[3] = 1'b1;
        expect_strobe(5'h03, cyc + LAT, 1'b0);
        wait_neg(10);
        pb[1] = 1'b1;
        wait_neg(10);
        check("hold2_code", {27'd0, code}, 32'h03);
        check("hold2_held", {31'd0, held}, 32'd1);
        check("hold2_multi", {31'd0, multi}, 32'd1);
        pb = '0;
        wait_neg(LAT + 1);
        check("hold2_release_held", {31'd0, held}, 32'd0);
        pb[1] = 1'b1;
        expect_strobe(5'h01, cyc + LAT, 1'b0);
        wait_neg(10);
        pb = '0;
        wait_neg(LAT + 1);

        // Enable gating on key 19
        enable = 1'b0;
        pb[19] = 1'b1;
        wait_neg(10);
        check("gated_held", {31'd0, held}, 32'd0);
        check("gated_code", {27'd0, code}, 32'h01);
        enable = 1'b1;
        expect_strobe(KEY_YEL, cyc + 1, 1'b0);
        wait_neg(5);
        pb = '0;
        wait_neg(LAT + 1);

        // Async reset during the strobe cycle, key 2 kept down
        pb[2] = 1'b1;
        expect_strobe(5'h02, cyc + LAT, 1'b0);
        wait_neg(LAT);
        #1;
        check("pre_reset_strobe", {31'd0, strobe}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_strobe", {31'd0, strobe}, 32'd0);
        check("async_code", {27'd0, code}, 32'd0);
        check("async_held", {31'd0, held}, 32'd0);
        wait_neg(2);
        reset = 1'b0;
        expect_strobe(5'h02, cyc + LAT, 1'b0);
        wait_neg(12);
        pb = '0;
        wait_neg(LAT + 3);

        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_strobe: got none, expected code 0x%0h at cycle %0d",
                     e.code, e.cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
